// File: rtl/block_swap_engine_pkg.sv
// Shared definitions for the block swap engine.
//
// Provides the block address width, the "empty slot" marker the request
// blocker stores for unused SRAM slots, default geometry for the swappable
// SRAM region, the swap FSM state type, and a helper that turns a block
// address plus word offset into a backing-memory byte address.
package block_swap_engine_pkg;

    // Width of a block address as stored in the blocker's address table.
    localparam int unsigned BLOCK_ADDR_W = 21;

    // Table entry value meaning "this slot holds no block".
    localparam logic [BLOCK_ADDR_W-1:0] BLOCK_INVALID_ADDR = 21'h1F_FFFF;

    // Default number of 32-bit words per block.
    localparam int unsigned BLOCK_WORDS = 16;

    // Default number of block-sized slots in the SRAM.
    localparam int unsigned NUM_SRAM_ADDRESSES = 8;

    // Default byte base of the swappable backing region.
    localparam logic [31:0] BACKING_BASE_DEFAULT = 32'h1000_0000;

    // Swap FSM states:
    //   IDLE  - waiting for a swap request
    //   WB_RD - read one word of the victim slot from SRAM
    //   WB_WR - write that word back to backing memory
    //   FETCH - read one word of the new block and store it in SRAM
    //   DONE  - one-cycle completion pulse to the blocker
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB_RD = 3'd1,
        WB_WR = 3'd2,
        FETCH = 3'd3,
        DONE  = 3'd4
    } swap_state_e;

    // Byte address of word 'word' inside block 'blk' of the backing region.
    // Computed 32 bits wide; any overflow simply wraps.
    function automatic logic [31:0] block_byte_addr(
        input logic [31:0]             base,
        input logic [BLOCK_ADDR_W-1:0] blk,
        input logic [31:0]             word,
        input int unsigned             blk_shift
    );
        return base + (32'(blk) << blk_shift) + (word << 2);
    endfunction

endpackage

// File: rtl/block_swap_engine.sv
// Block swap engine.
//
// Sits directly downstream of the request blocker. When the blocker asks
// for a swap, the engine copies the victim SRAM slot back to its home in
// backing memory (unless the slot is empty), then refills the same slot
// with the requested block, and finally pulses done_o so the blocker can
// update its address table and advance its victim pointer.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   swap_req_i           swap request level, held by the blocker
//   old_addr_idx_i       victim slot index
//   old_addr_i           block address currently held in the victim slot
//   new_addr_i           block address to load into the victim slot
//   done_o               one-cycle pulse when the swap has completed
//   busy_o               high whenever a swap is in progress
//   sram_*               single-port SRAM macro port, always granted,
//                        read data returned the cycle after the request
//   mem_*                OBI-style backing-memory manager port, at most
//                        one outstanding transaction
module block_swap_engine
    import block_swap_engine_pkg::*;
#(
    parameter int unsigned BlockWords  = BLOCK_WORDS,
    parameter logic [31:0] BackingBase = BACKING_BASE_DEFAULT,
    parameter int unsigned NumSlots    = NUM_SRAM_ADDRESSES,
    localparam int unsigned IdxW       = $clog2(NumSlots),
    localparam int unsigned WordW      = $clog2(BlockWords),
    localparam int unsigned SramAw     = $clog2(NumSlots * BlockWords),
    localparam int unsigned BlkShift   = $clog2(BlockWords * 4)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    swap_req_i,
    input  logic [IdxW-1:0]         old_addr_idx_i,
    input  logic [BLOCK_ADDR_W-1:0] old_addr_i,
    input  logic [BLOCK_ADDR_W-1:0] new_addr_i,
    output logic                    done_o,
    output logic                    busy_o,

    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [SramAw-1:0]       sram_addr_o,
    output logic [31:0]             sram_wdata_o,
    input  logic [31:0]             sram_rdata_i,

    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_rdata_i
);

    swap_state_e              state_q, state_d;
    logic [WordW-1:0]         word_q, word_d;
    logic [IdxW-1:0]          slot_q, slot_d;
    logic [BLOCK_ADDR_W-1:0]  old_blk_q, old_blk_d;
    logic [BLOCK_ADDR_W-1:0]  new_blk_q, new_blk_d;
    logic [31:0]              data_q, data_d;
    logic                     wait_rsp_q, wait_rsp_d;
    logic                     captured_q, captured_d;

    logic                     last_word;
    logic                     beat_done;
    logic [31:0]              wb_addr;
    logic [31:0]              fetch_addr;
    logic [31:0]              wb_wdata;
    logic [31:0]              sram_addr_full;

    // Address generation is shared by every state. Write-back targets the
    // latched old block, refill targets the latched new block, and the SRAM
    // word address is the slot base plus the running word counter.
    assign last_word      = (word_q == WordW'(BlockWords - 1));
    assign wb_addr        = block_byte_addr(BackingBase, old_blk_q, 32'(word_q), BlkShift);
    assign fetch_addr     = block_byte_addr(BackingBase, new_blk_q, 32'(word_q), BlkShift);
    assign sram_addr_full = 32'(slot_q) * BlockWords + 32'(word_q);

    // In the first WB_WR cycle the SRAM read data is still on the bus and has
    // not reached data_q yet, so it is forwarded directly. From the second
    // cycle on the captured copy is used, keeping the write data stable for
    // as long as the backing port withholds its grant.
    assign wb_wdata = captured_q ? data_q : sram_rdata_i;

    // A backing transaction finishes when rvalid arrives, either after an
    // earlier grant or together with the grant in the same cycle. This is
    // only looked at in WB_WR and FETCH, where mem_req_o is high whenever
    // no response is pending, so a grant here is a real handshake.
    assign beat_done = mem_rvalid_i && (wait_rsp_q || mem_gnt_i);

    // Next-state and output logic for the swap FSM. Everything the blocker
    // drives is latched in IDLE, because its index output moves as soon as
    // it sees done_o and the engine must keep working on the original slot.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        slot_d       = slot_q;
        old_blk_d    = old_blk_q;
        new_blk_d    = new_blk_q;
        data_d       = data_q;
        wait_rsp_d   = wait_rsp_q;
        captured_d   = captured_q;

        done_o       = 1'b0;
        busy_o       = (state_q != IDLE);
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        unique case (state_q)
            IDLE: begin
                if (swap_req_i) begin
                    slot_d     = old_addr_idx_i;
                    old_blk_d  = old_addr_i;
                    new_blk_d  = new_addr_i;
                    word_d     = '0;
                    wait_rsp_d = 1'b0;
                    captured_d = 1'b0;
                    // An empty slot has nothing worth saving.
                    state_d    = (old_addr_i != BLOCK_INVALID_ADDR) ? WB_RD : FETCH;
                end
            end

            WB_RD: begin
                sram_req_o  = 1'b1;
                sram_addr_o = SramAw'(sram_addr_full);
                captured_d  = 1'b0;
                state_d     = WB_WR;
            end

            WB_WR: begin
                if (!captured_q) begin
                    data_d     = sram_rdata_i;
                    captured_d = 1'b1;
                end
                mem_req_o   = !wait_rsp_q;
                mem_we_o    = 1'b1;
                mem_addr_o  = wb_addr;
                mem_wdata_o = wb_wdata;
                if (!wait_rsp_q && mem_gnt_i && !mem_rvalid_i) begin
                    wait_rsp_d = 1'b1;
                end
                if (beat_done) begin
                    wait_rsp_d = 1'b0;
                    captured_d = 1'b0;
                    if (last_word) begin
                        word_d  = '0;
                        state_d = FETCH;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = WB_RD;
                    end
                end
            end

            FETCH: begin
                mem_req_o  = !wait_rsp_q;
                mem_addr_o = fetch_addr;
                if (!wait_rsp_q && mem_gnt_i && !mem_rvalid_i) begin
                    wait_rsp_d = 1'b1;
                end
                // Returned data goes straight into the SRAM in the same cycle,
                // the only time both ports are active together.
                if (beat_done) begin
                    wait_rsp_d   = 1'b0;
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = SramAw'(sram_addr_full);
                    sram_wdata_o = mem_rdata_i;
                    if (last_word) begin
                        word_d  = '0;
                        state_d = DONE;
                    end else begin
                        word_d  = word_q + 1'b1;
                    end
                end
            end

            DONE: begin
                // The blocker updates its table on this edge, so going
                // straight to IDLE cannot re-accept the finished request.
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset abandons any swap in flight without a done
    // pulse; the partially refilled slot is left as it is.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            word_q     <= '0;
            slot_q     <= '0;
            old_blk_q  <= '0;
            new_blk_q  <= '0;
            data_q     <= '0;
            wait_rsp_q <= 1'b0;
            captured_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            slot_q     <= slot_d;
            old_blk_q  <= old_blk_d;
            new_blk_q  <= new_blk_d;
            data_q     <= data_d;
            wait_rsp_q <= wait_rsp_d;
            captured_q <= captured_d;
        end
    end

endmodule

// File: tb/tb_block_swap_engine.sv
// Self-checking bench for block_swap_engine.
//
// A behavioural SRAM and backing memory surround the engine. Each swap the
// stimulus issues is turned into the list of backing transactions, SRAM
// writes and done pulses it must produce; a monitor consumes those lists as
// the engine acts on its ports.
module tb_block_swap_engine;

    localparam int          BW   = 16;
    localparam int          NS   = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [20:0] INV  = 21'h1F_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        swap_req_i = 1'b0;
    logic [2:0]  old_addr_idx_i = '0;
    logic [20:0] old_addr_i = '0;
    logic [20:0] new_addr_i = '0;
    logic        done_o, busy_o;
    logic        sram_req_o, sram_we_o;
    logic [6:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i = '0;
    logic        mem_req_o, mem_we_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    block_swap_engine #(
        .BlockWords (BW),
        .BackingBase(BASE),
        .NumSlots   (NS)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .swap_req_i    (swap_req_i),
        .old_addr_idx_i(old_addr_idx_i),
        .old_addr_i    (old_addr_i),
        .new_addr_i    (new_addr_i),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .sram_req_o    (sram_req_o),
        .sram_we_o     (sram_we_o),
        .sram_addr_o   (sram_addr_o),
        .sram_wdata_o  (sram_wdata_o),
        .sram_rdata_i  (sram_rdata_i),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } sram_exp_t;

    int          total = 0;
    int          bad = 0;
    mem_exp_t    exp_mem[$];
    sram_exp_t   exp_sram[$];
    int          exp_done[$];
    int          done_cnt = 0;
    int          sram_wr_cnt = 0;
    int          mem_wr_cnt = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic [31:0] backing[logic [31:0]];
    logic [31:0] sram_mem[NS*BW];
    bit          sram_written[NS*BW];
    logic [31:0] seed = 32'h0;
    logic [31:0] rd_next = 32'h0;

    // Pass/fail bookkeeping shared by every comparison.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNote(input string name, input logic [31:0] actual);
        total++;
        bad++;
        $display("[TB] FAIL %s: got 0x%08h, expected nothing at %0t", name, actual, $time);
    endtask

    // SRAM contents: words never written hold a seed-dependent pattern.
    function automatic logic [31:0] sramPeek(input int a);
        return sram_written[a] ? sram_mem[a] : (seed ^ (32'(a) * 32'h9E37_79B9));
    endfunction

    // SRAM model, sampled mid-cycle when the port is stable.
    always @(negedge clk) begin
        if (rst_n && sram_req_o) begin
            if (sram_we_o) begin
                sram_mem[sram_addr_o]     = sram_wdata_o;
                sram_written[sram_addr_o] = 1'b1;
            end else begin
                rd_next = sramPeek(int'(sram_addr_o));
            end
        end
    end

    // Read data and backing-memory responses for the coming cycle.
    int          gnt_cnt = 0;
    int          pend_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    always @(posedge clk) begin
        #1;
        sram_rdata_i = rd_next;
        #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (!rst_n) begin
            pend    = 1'b0;
            gnt_cnt = 0;
        end else if (pend) begin
            if (pend_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_data;
                pend         = 1'b0;
            end else begin
                pend_cnt--;
            end
        end else if (mem_req_o) begin
            if (gnt_cnt >= gnt_delay) begin
                mem_gnt_i = 1'b1;
                gnt_cnt   = 0;
                if (mem_we_o) pend_data = $urandom;
                else pend_data = backing.exists(mem_addr_o) ? backing[mem_addr_o] : 32'hDEAD_BEEF;
                if (rv_delay == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pend_data;
                end else begin
                    pend     = 1'b1;
                    pend_cnt = rv_delay - 1;
                end
            end else begin
                gnt_cnt++;
            end
        end
    end

    // Monitor: compares every port event against the expected queues and
    // checks that a stalled request keeps its address and data.
    logic        prev_stall = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    mem_exp_t    me;
    sram_exp_t   se;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_req_held", 32'(mem_req_o), 32'd1);
                checkOutput("stall_we_held", 32'(mem_we_o), 32'(prev_we));
                checkOutput("stall_addr_held", mem_addr_o, prev_addr);
                if (prev_we) checkOutput("stall_wdata_held", mem_wdata_o, prev_wdata);
            end
            prev_stall = mem_req_o && !mem_gnt_i;
            prev_we    = mem_we_o;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;

            if (sram_req_o && mem_req_o)
                checkOutput("port_overlap", 32'({sram_we_o, mem_rvalid_i}), 32'd3);

            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) mem_wr_cnt++;
                if (exp_mem.size() == 0) begin
                    failNote("mem_unexpected", mem_addr_o);
                end else begin
                    me = exp_mem.pop_front();
                    checkOutput("mem_we", 32'(mem_we_o), 32'(me.we));
                    checkOutput("mem_addr", mem_addr_o, me.addr);
                    if (me.we) checkOutput("mem_wdata", mem_wdata_o, me.wdata);
                end
            end

            if (sram_req_o && sram_we_o) begin
                sram_wr_cnt++;
                if (exp_sram.size() == 0) begin
                    failNote("sram_unexpected", 32'(sram_addr_o));
                end else begin
                    se = exp_sram.pop_front();
                    checkOutput("sram_addr", 32'(sram_addr_o), 32'(se.addr));
                    checkOutput("sram_wdata", sram_wdata_o, se.data);
                end
            end

            if (done_o) begin
                done_cnt++;
                if (exp_done.size() == 0) failNote("done_unexpected", 32'(done_cnt));
                else void'(exp_done.pop_front());
            end
        end
    end

    // Reference model of one swap: write-back of the old block (unless the
    // slot is empty), refill from the new block, then one done pulse.
    task automatic pushExpect(input int slot, input logic [20:0] old_blk, input logic [20:0] new_blk);
        logic [31:0] a;
        logic [31:0] d;
        if (old_blk != INV) begin
            for (int w = 0; w < BW; w++) begin
                a = BASE + 32'(old_blk) * 32'(BW * 4) + 32'(w * 4);
                exp_mem.push_back('{we: 1'b1, addr: a, wdata: sramPeek(slot * BW + w)});
            end
        end
        for (int w = 0; w < BW; w++) begin
            a = BASE + 32'(new_blk) * 32'(BW * 4) + 32'(w * 4);
            d = $urandom;
            backing[a] = d;
            exp_mem.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
            exp_sram.push_back('{addr: 7'(slot * BW + w), data: d});
        end
        exp_done.push_back(1);
    endtask

    task automatic checkIdle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #3;
            checkOutput(name, 32'({busy_o, done_o, mem_req_o, sram_req_o}), 32'd0);
        end
    endtask

    // Issues one swap and waits for it to finish. With hold_req the request
    // stays up until done is seen; otherwise it drops right after acceptance
    // and the blocker-side inputs are scrambled.
    task automatic applyStimulus(input int slot, input logic [20:0] old_blk, input logic [20:0] new_blk,
                                 input int gd, input int rd, input bit hold_req);
        int start_done;
        int c;
        gnt_delay = gd;
        rv_delay  = rd;
        pushExpect(slot, old_blk, new_blk);
        start_done     = done_cnt;
        swap_req_i     = 1'b1;
        old_addr_idx_i = 3'(slot);
        old_addr_i     = old_blk;
        new_addr_i     = new_blk;
        @(posedge clk);
        #3;
        checkOutput("busy_after_accept", 32'(busy_o), 32'd1);
        if (!hold_req) begin
            swap_req_i     = 1'b0;
            old_addr_idx_i = 3'($urandom);
            old_addr_i     = 21'($urandom);
            new_addr_i     = 21'($urandom);
        end
        c = 0;
        while (done_cnt == start_done && c < 3000) begin
            @(posedge clk);
            #3;
            c++;
        end
        if (done_cnt == start_done) failNote("done_timeout", 32'(c));
        swap_req_i = 1'b0;
        checkIdle("idle_after_done", 3);
        checkOutput("done_count", 32'(done_cnt - start_done), 32'd1);
        for (int w = 0; w < BW; w += 5)
            checkOutput("slot_content", sramPeek(slot * BW + w),
                        backing[BASE + 32'(new_blk) * 32'(BW * 4) + 32'(w * 4)]);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          slot;
        int          wr_before;
        int          base_wr;
        int          saved_done;
        int          c;
        logic [20:0] ob;
        logic [20:0] nb;

        seed = $urandom;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset_ctrl", 32'({done_o, busy_o, sram_req_o, sram_we_o, mem_req_o, mem_we_o}), 32'd0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'd0);
        checkOutput("reset_wdata", mem_wdata_o | sram_wdata_o, 32'd0);
        checkOutput("reset_sram_addr", 32'(sram_addr_o), 32'd0);
        rst_n = 1'b1;
        checkIdle("idle_no_request", 4);

        $display("[TB] full swap slot 1, old 0x2 -> new 0x5");
        applyStimulus(1, 21'h000002, 21'h000005, 0, 0, 1'b1);

        $display("[TB] empty slot refill");
        wr_before = mem_wr_cnt;
        applyStimulus(3, INV, 21'h000007, 0, 0, 1'b1);
        checkOutput("empty_slot_writes", 32'(mem_wr_cnt - wr_before), 32'd0);

        $display("[TB] backpressure: grant after 3, rvalid 2 after grant");
        applyStimulus(1, 21'h000005, 21'h000009, 3, 2, 1'b0);

        $display("[TB] randomized swaps");
        for (int i = 0; i < 5; i++) begin
            slot = $urandom_range(0, NS - 1);
            ob   = ($urandom_range(0, 3) == 0) ? INV : 21'($urandom_range(0, 21'h1F_FFFE));
            nb   = 21'($urandom_range(0, 21'h1F_FFFE));
            if (nb == ob) nb = (ob == 21'd0) ? 21'd1 : 21'd0;
            applyStimulus(slot, ob, nb, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        $display("[TB] reset during refill");
        gnt_delay  = 0;
        rv_delay   = 0;
        pushExpect(2, INV, 21'h00000B);
        base_wr    = sram_wr_cnt;
        saved_done = done_cnt;
        swap_req_i     = 1'b1;
        old_addr_idx_i = 3'd2;
        old_addr_i     = INV;
        new_addr_i     = 21'h00000B;
        c = 0;
        while (sram_wr_cnt - base_wr < 7 && c < 500) begin
            @(posedge clk);
            #3;
            c++;
        end
        if (sram_wr_cnt - base_wr < 7) failNote("refill_timeout", 32'(sram_wr_cnt - base_wr));
        rst_n      = 1'b0;
        swap_req_i = 1'b0;
        exp_mem.delete();
        exp_sram.delete();
        exp_done.delete();
        @(posedge clk);
        #3;
        checkOutput("reset_mid_fetch", 32'({busy_o, done_o, mem_req_o, sram_req_o}), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        checkIdle("idle_after_reset", 3);
        checkOutput("no_done_after_reset", 32'(done_cnt), 32'(saved_done));
        applyStimulus(2, INV, 21'h00000B, 0, 0, 1'b1);

        checkOutput("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        checkOutput("sram_queue_drained", 32'(exp_sram.size()), 32'd0);
        checkOutput("done_queue_drained", 32'(exp_done.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
